// File: rtl/cv32e40p_cg_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cv32e40p_cg_pkg
// Brief   : Shared types and constants for the core clock-gate controller.
// Revision: 1.0 - initial release
// ============================================================================
package cv32e40p_cg_pkg;

  typedef enum logic [2:0] {
    BOOT  = 3'd0,
    RUN   = 3'd1,
    DRAIN = 3'd2,
    SLEEP = 3'd3,
    WAKE  = 3'd4
  } cg_state_e;

  localparam int unsigned CG_MAX_W = 64;
  localparam logic [CG_MAX_W-1:0] CG_ALL_ONES = '1;

  // Width able to hold max(a,b) so both the idle and wake counters share it.
  function automatic int unsigned cg_cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cv32e40p_cg_sat_cnt.sv
`default_nettype none
// ============================================================================
// Module  : cv32e40p_cg_sat_cnt
// Brief   : Saturating up-counter with synchronous clear (clear wins).
// Revision: 1.0 - initial release
// ============================================================================
module cv32e40p_cg_sat_cnt
  import cv32e40p_cg_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  localparam logic [WIDTH-1:0] SAT_VAL = CG_ALL_ONES[WIDTH-1:0];

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if (clr_i) begin
      r_cnt <= '0;
    end else if (inc_i && (r_cnt != SAT_VAL)) begin
      r_cnt <= r_cnt + WIDTH'(1);
    end
  end

  assign cnt_o = r_cnt;

endmodule
`default_nettype wire

// File: rtl/cv32e40p_clock_gate_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : cv32e40p_clock_gate_ctrl
// Brief   : Sleep/wake FSM driving the core clock-gate enable, with statistics.
// Revision: 1.0 - initial release
// ============================================================================
module cv32e40p_clock_gate_ctrl
  import cv32e40p_cg_pkg::*;
#(
  parameter int unsigned IDLE_CYCLES = 2,
  parameter int unsigned WAKE_CYCLES = 1,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             fetch_enable_i,
  input  logic             sleep_req_i,
  input  logic             core_busy_i,
  input  logic             lsu_busy_i,
  input  logic             wake_i,
  input  logic             debug_req_i,
  input  logic             clr_stats_i,
  output logic             clock_en_o,
  output logic             core_sleep_o,
  output logic             wake_ack_o,
  output logic [CNT_W-1:0] gated_cycles_o
);

  localparam int unsigned      CW        = cg_cnt_width(IDLE_CYCLES, WAKE_CYCLES);
  localparam logic [CW-1:0]    IDLE_LAST = CW'(IDLE_CYCLES - 1);
  localparam logic [CW-1:0]    WAKE_LAST = CW'(WAKE_CYCLES - 1);

  cg_state_e     r_state, w_state_nxt;
  logic [CW-1:0] r_idle_cnt, w_idle_cnt_nxt;
  logic [CW-1:0] r_wake_cnt, w_wake_cnt_nxt;
  logic          r_wake_ack, w_wake_ack_nxt;
  logic          w_wake_evt;
  logic          w_busy;

  assign w_wake_evt = wake_i | debug_req_i;
  assign w_busy     = core_busy_i | lsu_busy_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= BOOT;
      r_idle_cnt <= '0;
      r_wake_cnt <= '0;
      r_wake_ack <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_idle_cnt <= w_idle_cnt_nxt;
      r_wake_cnt <= w_wake_cnt_nxt;
      r_wake_ack <= w_wake_ack_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_idle_cnt_nxt = r_idle_cnt;
    w_wake_cnt_nxt = r_wake_cnt;
    w_wake_ack_nxt = 1'b0;
    case (r_state)
      BOOT: begin
        if (fetch_enable_i) w_state_nxt = RUN;
      end
      RUN: begin
        if (sleep_req_i && !w_wake_evt) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        // Abort is checked first so a late wake never lets the gate close.
        if (w_wake_evt || !sleep_req_i) begin
          w_state_nxt = RUN;
        end else if (w_busy) begin
          w_idle_cnt_nxt = '0;
        end else if (r_idle_cnt == IDLE_LAST) begin
          w_state_nxt = SLEEP;
        end else begin
          w_idle_cnt_nxt = r_idle_cnt + CW'(1);
        end
      end
      SLEEP: begin
        if (w_wake_evt) w_state_nxt = WAKE;
      end
      WAKE: begin
        if (r_wake_cnt == WAKE_LAST) begin
          w_state_nxt    = RUN;
          w_wake_ack_nxt = 1'b1;
        end else begin
          w_wake_cnt_nxt = r_wake_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nxt = BOOT;
      end
    endcase
    if (w_state_nxt != r_state) begin
      w_idle_cnt_nxt = '0;
      w_wake_cnt_nxt = '0;
    end
  end

  cv32e40p_cg_sat_cnt #(
    .WIDTH (CNT_W)
  ) u_gated_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (clr_stats_i),
    .inc_i  (r_state == SLEEP),
    .cnt_o  (gated_cycles_o)
  );

  assign clock_en_o   = (r_state == RUN) || (r_state == DRAIN) || (r_state == WAKE);
  assign core_sleep_o = (r_state == SLEEP);
  assign wake_ack_o   = r_wake_ack;

endmodule
`default_nettype wire
